// File: rtl/fix_add_pkg.sv
// rtl/fix_add_pkg.sv - shared types, defaults and helpers for the fix_add arbiter slice
// Contents: default widths, sign-magnitude operand/result types, response
// state encoding and a zero-magnitude test.
package fix_add_pkg;

  localparam int N_DEF    = 32;
  localparam int NREQ_DEF = 4;

  // {sign, N-bit magnitude} and {sign, N+1-bit magnitude} at default width
  typedef logic [N_DEF:0]   sm_operand_t;
  typedef logic [N_DEF+1:0] sm_result_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } resp_state_t;

  // Callers zero-extend their magnitude to 64 bits, so this covers any N up to 63.
  function automatic logic sm_is_zero(input logic [63:0] mag);
    return mag == 64'd0;
  endfunction

endpackage

// File: rtl/fix_add.sv
// rtl/fix_add.sv - combinational sign-magnitude fixed-point adder
// Ports:
//   a, b : {sign, N-bit magnitude} operands
//   sum  : {sign, N+1-bit magnitude} exact result
module fix_add
  import fix_add_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N:0]   a,
  input  logic [N:0]   b,
  output logic [N+1:0] sum
);

  logic [N:0] mag_a;
  logic [N:0] mag_b;
  logic [N:0] mag_s;
  logic       sign_s;

  always_comb begin
    mag_a = {1'b0, a[N-1:0]};
    mag_b = {1'b0, b[N-1:0]};
    mag_s = '0;
    sign_s = 1'b0;
    if (a[N] == b[N]) begin
      // Like signs keep the sign, so -0 + -0 comes out as -0.
      mag_s  = mag_a + mag_b;
      sign_s = a[N];
    end else if (mag_a >= mag_b) begin
      mag_s  = mag_a - mag_b;
      // Cancellation of unlike signs is always reported as +0.
      sign_s = sm_is_zero(64'(mag_s)) ? 1'b0 : a[N];
    end else begin
      mag_s  = mag_b - mag_a;
      sign_s = b[N];
    end
    sum = {sign_s, mag_s};
  end

endmodule

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter
// Ports:
//   req : request vector
//   ptr : index with highest priority this cycle
//   en  : allow a grant to be issued
//   gnt : one-hot grant (zero when en=0 or no request)
//   idx : index of the winning request (0 when none)
//   any : at least one request present
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    // Walk ptr, ptr+1, ... modulo NREQ; the first request seen wins.
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IDW'(j);
      end
    end
    if (en && any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fix_add_arb.sv
// rtl/fix_add_arb.sv - round-robin sharing of one fix_add between NREQ requesters
// Optional feature macro: FIX_ADD_ARB_SAT_EN (clamp magnitude to 2^N-1, flag resp_sat)
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake
//   req_a/req_b           : flat operand arrays, requester i at [i*(N+1) +: N+1]
//   resp_valid/resp_ready : result handshake
//   resp_sum/resp_id      : registered result and owning requester
//   resp_sat              : result was clamped (0 without the feature)
//   txn_cnt               : completed responses, wrapping
module fix_add_arb
  import fix_add_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*(N+1)-1:0] req_a,
  input  logic [NREQ*(N+1)-1:0] req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [N+1:0]         resp_sum,
  output logic [IDW-1:0]       resp_id,
  output logic                 resp_sat,
  output logic [CNTW-1:0]      txn_cnt
);

  resp_state_t     state_q, state_d;
  logic [N+1:0]    sum_q, sum_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            sat_q, sat_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            can_accept;
  logic            arb_en;
  logic            win_any;
  logic [IDW-1:0]  win_idx;
  logic            accept;
  logic            drain;
  logic [N:0]      op_a;
  logic [N:0]      op_b;
  logic [N+1:0]    add_sum;
  logic [N+1:0]    res_sum;
  logic            res_sat;

  // Single output register: it may be refilled in the cycle it drains.
  // Gating with rst_n keeps requesters from seeing a grant during reset.
  assign can_accept = (state_q == ST_EMPTY) || resp_ready;
  assign arb_en     = can_accept && rst_n;
  assign accept     = win_any && arb_en;
  assign drain      = (state_q == ST_FULL) && resp_ready;

  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (req_ready),
    .idx (win_idx),
    .any (win_any)
  );

  assign op_a = req_a[win_idx*(N+1) +: N+1];
  assign op_b = req_b[win_idx*(N+1) +: N+1];

  fix_add #(
    .N (N)
  ) u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  always_comb begin
    res_sum = add_sum;
    res_sat = 1'b0;
`ifdef FIX_ADD_ARB_SAT_EN
    if (add_sum[N]) begin
      res_sum = {add_sum[N+1], 1'b0, {N{1'b1}}};
      res_sat = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    id_d    = id_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (!accept && resp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      sum_d = res_sum;
      id_d  = win_idx;
      sat_d = res_sat;
      ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
    if (drain) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign resp_valid = (state_q == ST_FULL);
  assign resp_sum   = sum_q;
  assign resp_id    = id_q;
  assign resp_sat   = sat_q;
  assign txn_cnt    = cnt_q;

endmodule
